// File: rtl/debounce_pkg.sv
// Shared definitions for the pushbutton debouncer: FSM state encoding and
// the width of the optional press counter.
package debounce_pkg;

  localparam int PRESS_W = 8;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; both stages reset to 0
// on a synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= d;
      ff2_q <= ff1_q;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/button_debouncer.sv
// Pushbutton debouncer: 2-flop synchroniser, counter-qualified level FSM,
// registered rise/fall pulses; `PRESS_COUNT_EN adds an 8-bit press counter.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 250000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_raw,
  output logic               btn_level,
  output logic               rise_pulse,
  output logic               fall_pulse
`ifdef PRESS_COUNT_EN
  ,
  output logic [PRESS_W-1:0] press_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             btnSync;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             btnLevel_q;
  logic             risePulse_q;
  logic             fallPulse_q;
  logic             acceptRise_d;
  logic             acceptFall_d;

  sync_2ff uSync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_raw),
    .q    (btnSync)
  );

  // The sample that completes qualification is itself the last stable one.
  assign acceptRise_d = (state_q == WAIT_HIGH) && btnSync  && (cnt_q == CNT_LAST);
  assign acceptFall_d = (state_q == WAIT_LOW)  && !btnSync && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE_LOW;
      cnt_q       <= '0;
      btnLevel_q  <= 1'b0;
      risePulse_q <= 1'b0;
      fallPulse_q <= 1'b0;
    end else begin
      risePulse_q <= 1'b0;
      fallPulse_q <= 1'b0;
      unique case (state_q)
        IDLE_LOW: begin
          if (btnSync) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!btnSync) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
          end else if (acceptRise_d) begin
            state_q     <= IDLE_HIGH;
            cnt_q       <= '0;
            btnLevel_q  <= 1'b1;
            risePulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!btnSync) begin
            state_q <= WAIT_LOW;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        WAIT_LOW: begin
          if (btnSync) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
          end else if (acceptFall_d) begin
            state_q     <= IDLE_LOW;
            cnt_q       <= '0;
            btnLevel_q  <= 1'b0;
            fallPulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign btn_level  = btnLevel_q;
  assign rise_pulse = risePulse_q;
  assign fall_pulse = fallPulse_q;

`ifdef PRESS_COUNT_EN
  logic [PRESS_W-1:0] pressCnt_q;

  // Counts in lockstep with rise_pulse; wraps naturally at 2^PRESS_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pressCnt_q <= '0;
    end else if (acceptRise_d) begin
      pressCnt_q <= pressCnt_q + PRESS_W'(1);
    end
  end

  assign press_count = pressCnt_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (STABLE_CYCLES=4, 40 ns clock):
// run-length reference model compared every cycle plus pinned literal checks.
module tb_button_debouncer;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_raw;
  logic       btn_level;
  logic       rise_pulse;
  logic       fall_pulse;
`ifdef PRESS_COUNT_EN
  logic [7:0] press_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model: raw delayed two samples, then a run of STABLE samples
  // differing from the current level flips it.
  logic mSync1  = 1'b0;
  logic mSync2  = 1'b0;
  logic mLevel  = 1'b0;
  logic mRise   = 1'b0;
  logic mFall   = 1'b0;
  int   mRun    = 0;
  int   mPress  = 0;
  bit   checkEn = 1'b0;

  int dutRises = 0;
  int dutFalls = 0;

  button_debouncer #(.STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
`ifdef PRESS_COUNT_EN
    ,
    .press_count(press_count)
`endif
  );

  always #20 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep();
    logic s;
    if (!rst_n) begin
      mSync1 = 1'b0; mSync2 = 1'b0; mLevel = 1'b0;
      mRise = 1'b0; mFall = 1'b0; mRun = 0; mPress = 0;
      checkEn = 1'b1;
    end else begin
      s = mSync2;
      mSync2 = mSync1;
      mSync1 = btn_raw;
      mRise = 1'b0;
      mFall = 1'b0;
      if (s !== mLevel) begin
        mRun++;
        if (mRun == STABLE) begin
          mLevel = s;
          mRun = 0;
          if (s) begin
            mRise = 1'b1;
            mPress = (mPress + 1) % 256;
          end else begin
            mFall = 1'b1;
          end
        end
      end else begin
        mRun = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic value, input int cycles);
    btn_raw = value;
    repeat (cycles) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (checkEn) begin
      checkOutput("btn_level", 32'(btn_level), 32'(mLevel));
      checkOutput("rise_pulse", 32'(rise_pulse), 32'(mRise));
      checkOutput("fall_pulse", 32'(fall_pulse), 32'(mFall));
      checkOutput("pulseExclusive", 32'(rise_pulse & fall_pulse), 32'd0);
`ifdef PRESS_COUNT_EN
      checkOutput("press_count", 32'(press_count), 32'(mPress));
`endif
      if (rise_pulse === 1'b1) dutRises++;
      if (fall_pulse === 1'b1) dutFalls++;
    end
  end

  initial begin
    int risesStart;
    int fallsStart;
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    @(negedge clk);

    // Reset with raw input toggling: everything must stay at 0.
    for (int i = 0; i < 3; i++) begin
      btn_raw = ~btn_raw;
      @(negedge clk);
      checkOutput("resetLevel", 32'(btn_level), 32'd0);
      checkOutput("resetRise", 32'(rise_pulse), 32'd0);
    end
    rst_n = 1'b1;
    applyStimulus(1'b0, 4);

    // Clean press: level and rise at edge 6, pulse gone at edge 7.
    btn_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 5) checkOutput("pressLevelEdge5", 32'(btn_level), 32'd0);
      if (i == 6) checkOutput("pressLevelEdge6", 32'(btn_level), 32'd1);
      if (i == 6) checkOutput("pressRiseEdge6", 32'(rise_pulse), 32'd1);
      if (i == 7) checkOutput("pressRiseEdge7", 32'(rise_pulse), 32'd0);
    end
`ifdef PRESS_COUNT_EN
    checkOutput("pressCountOne", 32'(press_count), 32'd1);
`endif
    checkOutput("modelPressOne", 32'(mPress), 32'd1);
    applyStimulus(1'b0, 10);
    checkOutput("releaseLevel", 32'(btn_level), 32'd0);

    // Bounce rejection: runs of 3 never qualify.
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 8);
    checkOutput("bounceLevel", 32'(btn_level), 32'd0);
    checkOutput("bounceRises", 32'(dutRises), 32'd1);

    // Bounce then settle: rise at edge 6 from the last 0->1.
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 1);
    btn_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 5) checkOutput("settleRiseEdge5", 32'(rise_pulse), 32'd0);
      if (i == 6) checkOutput("settleRiseEdge6", 32'(rise_pulse), 32'd1);
    end
    checkOutput("settleRises", 32'(dutRises), 32'd2);
    applyStimulus(1'b0, 8);

    // Reset during WAIT_HIGH with cnt=2, raw held high through it.
    applyStimulus(1'b1, 4);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midResetRise", 32'(rise_pulse), 32'd0);
    checkOutput("midResetLevel", 32'(btn_level), 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 5) checkOutput("afterResetRise5", 32'(rise_pulse), 32'd0);
      if (i == 6) checkOutput("afterResetRise6", 32'(rise_pulse), 32'd1);
    end
`ifdef PRESS_COUNT_EN
    checkOutput("afterResetCount", 32'(press_count), 32'd1);
`endif
    applyStimulus(1'b0, 8);

    // Random runs around the qualification threshold, occasional reset.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 7)));
    end
    applyStimulus(1'b0, 8);

    // 256 clean press/release pairs from reset: counter wraps back to 0.
    rst_n = 1'b0;
    applyStimulus(1'b0, 2);
    rst_n = 1'b1;
    applyStimulus(1'b0, 3);
    risesStart = dutRises;
    fallsStart = dutFalls;
    for (int k = 0; k < 256; k++) begin
      applyStimulus(1'b1, 6);
      applyStimulus(1'b0, 6);
    end
    @(negedge clk);
    checkOutput("wrapRises", 32'(dutRises - risesStart), 32'd256);
    checkOutput("wrapFalls", 32'(dutFalls - fallsStart), 32'd256);
    checkOutput("modelPressWrap", 32'(mPress), 32'd0);
`ifdef PRESS_COUNT_EN
    checkOutput("pressCountWrap", 32'(press_count), 32'd0);
`endif
    checkOutput("wrapLevel", 32'(btn_level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
